// File: rtl/csr_timer_port.sv
// -----------------------------------------------------------------------------
// csr_timer_port
//
// CSR-side 32-bit window onto the 64-bit free-running timer.
//  - Reads use a high-half snapshot: reading TIME_LO captures the upper word,
//    so a following TIME_HI read is consistent even if a carry happened.
//  - Writes stage TIME_LO and commit both halves atomically on TIME_HI as a
//    one-cycle load strobe towards the timer.
//  - Holds a 64-bit compare value and raises a registered, level interrupt
//    when the timer value is greater than or equal to it.
//
// Ports
//  clk, rst_n      : core clock, asynchronous active-low reset
//  sel_i[1:0]      : 0 TIME_LO, 1 TIME_HI, 2 CMP_LO, 3 CMP_HI
//  rd_en_i         : read strobe (one cycle)
//  wr_en_i         : write strobe (one cycle)
//  wdata_i[31:0]   : write data
//  rdata_o[31:0]   : registered read data
//  rvalid_o        : one-cycle pulse marking rdata_o valid
//  timer_val_i[63:0]: current timer count
//  timer_we_o      : one-cycle timer load strobe
//  timer_val_o[63:0]: timer load value, valid with timer_we_o
//  irq_o           : timer interrupt pending (registered level)
// -----------------------------------------------------------------------------
module csr_timer_port #(
    parameter int CSR_XLEN = 64,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          sel_i,
    input  logic                rd_en_i,
    input  logic                wr_en_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rvalid_o,
    input  logic [CSR_XLEN-1:0] timer_val_i,
    output logic                timer_we_o,
    output logic [CSR_XLEN-1:0] timer_val_o,
    output logic                irq_o
);

    localparam logic [1:0] SEL_TIME_LO = 2'd0;
    localparam logic [1:0] SEL_TIME_HI = 2'd1;
    localparam logic [1:0] SEL_CMP_LO  = 2'd2;
    localparam logic [1:0] SEL_CMP_HI  = 2'd3;

    logic [DATA_W-1:0]   rdata_q,     rdata_d;
    logic                rvalid_q,    rvalid_d;
    logic [DATA_W-1:0]   shadow_hi_q, shadow_hi_d;
    logic                shadow_vld_q, shadow_vld_d;
    logic [DATA_W-1:0]   wlo_buf_q,   wlo_buf_d;
    logic                wlo_vld_q,   wlo_vld_d;
    logic [CSR_XLEN-1:0] cmp_q,       cmp_d;
    logic                timer_we_q,  timer_we_d;
    logic [CSR_XLEN-1:0] timer_val_q, timer_val_d;
    logic                irq_q,       irq_d;

    always_comb begin
        rdata_d      = rdata_q;
        rvalid_d     = rd_en_i;
        shadow_hi_d  = shadow_hi_q;
        shadow_vld_d = shadow_vld_q;
        wlo_buf_d    = wlo_buf_q;
        wlo_vld_d    = wlo_vld_q;
        cmp_d        = cmp_q;
        timer_we_d   = 1'b0;
        timer_val_d  = timer_val_q;
        irq_d        = (timer_val_i >= cmp_q);

        // Read path only looks at current (pre-write) register state.
        if (rd_en_i) begin
            case (sel_i)
                SEL_TIME_LO: begin
                    rdata_d      = timer_val_i[DATA_W-1:0];
                    shadow_hi_d  = timer_val_i[CSR_XLEN-1:DATA_W];
                    shadow_vld_d = 1'b1;
                end
                SEL_TIME_HI: begin
                    rdata_d      = shadow_vld_q ? shadow_hi_q
                                                : timer_val_i[CSR_XLEN-1:DATA_W];
                    shadow_vld_d = 1'b0;
                end
                SEL_CMP_LO:  rdata_d = cmp_q[DATA_W-1:0];
                default:     rdata_d = cmp_q[CSR_XLEN-1:DATA_W];
            endcase
        end

        if (wr_en_i) begin
            case (sel_i)
                SEL_TIME_LO: begin
                    wlo_buf_d = wdata_i;
                    wlo_vld_d = 1'b1;
                end
                SEL_TIME_HI: begin
                    // Without a staged low word, keep the timer's own low half.
                    timer_we_d  = 1'b1;
                    timer_val_d = {wdata_i, (wlo_vld_q ? wlo_buf_q
                                                       : timer_val_i[DATA_W-1:0])};
                    wlo_vld_d   = 1'b0;
                end
                SEL_CMP_LO: begin
                    cmp_d[DATA_W-1:0] = wdata_i;
                    irq_d             = 1'b0;
                end
                default: begin
                    cmp_d[CSR_XLEN-1:DATA_W] = wdata_i;
                    irq_d                    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            shadow_hi_q  <= '0;
            shadow_vld_q <= 1'b0;
            wlo_buf_q    <= '0;
            wlo_vld_q    <= 1'b0;
            cmp_q        <= '1;
            timer_we_q   <= 1'b0;
            timer_val_q  <= '0;
            irq_q        <= 1'b0;
        end else begin
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            shadow_hi_q  <= shadow_hi_d;
            shadow_vld_q <= shadow_vld_d;
            wlo_buf_q    <= wlo_buf_d;
            wlo_vld_q    <= wlo_vld_d;
            cmp_q        <= cmp_d;
            timer_we_q   <= timer_we_d;
            timer_val_q  <= timer_val_d;
            irq_q        <= irq_d;
        end
    end

    assign rdata_o     = rdata_q;
    assign rvalid_o    = rvalid_q;
    assign timer_we_o  = timer_we_q;
    assign timer_val_o = timer_val_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_csr_timer_port.sv
module tb_csr_timer_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sel_i;
    logic        rd_en_i;
    logic        wr_en_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic [63:0] timer_val_i;
    logic        timer_we_o;
    logic [63:0] timer_val_o;
    logic        irq_o;

    csr_timer_port #(.CSR_XLEN(64), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_i      (sel_i),
        .rd_en_i    (rd_en_i),
        .wr_en_i    (wr_en_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .rvalid_o   (rvalid_o),
        .timer_val_i(timer_val_i),
        .timer_we_o (timer_we_o),
        .timer_val_o(timer_val_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [63:0] val;
    } ld_t;

    logic [31:0] rdq[$];
    ld_t         ldq[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle; expected read data and expected load go to the scoreboards.
    task automatic op(input bit r, input bit w, input logic [1:0] s, input logic [31:0] wd,
                      input logic [31:0] erd, input bit eld, input logic [63:0] eval);
        ld_t e;
        rd_en_i = r;
        wr_en_i = w;
        sel_i   = s;
        wdata_i = wd;
        if (r) rdq.push_back(erd);
        if (eld) begin
            e.cyc = cyc + 1;
            e.val = eval;
            ldq.push_back(e);
        end
        tick();
        rd_en_i = 1'b0;
        wr_en_i = 1'b0;
    endtask

    // Monitor: read data and load strobes are checked against the queues.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rvalid_o) begin
                if (rdq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rvalid: got rdata 0x%0h expected no read", rdata_o);
                end else begin
                    chk("rdata", {32'h0, rdata_o}, {32'h0, rdq.pop_front()});
                end
            end
            if (timer_we_o) begin
                if (ldq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_load: got 0x%0h expected no timer_we_o", timer_val_o);
                end else begin
                    ld_t e;
                    e = ldq.pop_front();
                    chk("load_cycle", 64'(cyc), 64'(e.cyc));
                    chk("load_val", timer_val_o, e.val);
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, {32'h0, rdata_o}, 64'h0);
        chk({tag, "_rvalid"}, {63'h0, rvalid_o}, 64'h0);
        chk({tag, "_we"}, {63'h0, timer_we_o}, 64'h0);
        chk({tag, "_tval"}, timer_val_o, 64'h0);
        chk({tag, "_irq"}, {63'h0, irq_o}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        sel_i       = 2'd0;
        rd_en_i     = 1'b0;
        wr_en_i     = 1'b0;
        wdata_i     = 32'h0;
        timer_val_i = 64'h0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Compare register reset value
        op(1, 0, 2'd2, 0, 32'hFFFF_FFFF, 0, 0);
        op(1, 0, 2'd3, 0, 32'hFFFF_FFFF, 0, 0);

        // Carry-safe read
        timer_val_i = 64'h0000_0000_FFFF_FFFF;
        op(1, 0, 2'd0, 0, 32'hFFFF_FFFF, 0, 0);
        timer_val_i = 64'h0000_0001_0000_0002;
        op(1, 0, 2'd1, 0, 32'h0000_0000, 0, 0);
        op(1, 0, 2'd1, 0, 32'h0000_0001, 0, 0);

        // Atomic write
        op(0, 1, 2'd0, 32'h1234_5678, 0, 0, 0);
        op(0, 1, 2'd1, 32'h0000_0009, 0, 1, 64'h0000_0009_1234_5678);
        tick();

        // Unstaged HI write
        timer_val_i = 64'h0000_0003_0000_00AA;
        op(0, 1, 2'd1, 32'h5, 0, 1, 64'h0000_0005_0000_00AA);
        tick();

        // Last LO write wins
        op(0, 1, 2'd0, 32'h1, 0, 0, 0);
        op(0, 1, 2'd0, 32'h2, 0, 0, 0);
        op(0, 1, 2'd1, 32'h3, 0, 1, 64'h0000_0003_0000_0002);
        tick();

        // Reset mid-activity: snapshot and staged LO set, load strobe in flight
        timer_val_i = 64'h0000_0007_0000_0010;
        op(1, 1, 2'd0, 32'hDEAD_BEEF, 32'h0000_0010, 0, 0);
        op(0, 1, 2'd1, 32'h4, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        op(1, 0, 2'd2, 0, 32'hFFFF_FFFF, 0, 0);
        op(1, 0, 2'd3, 0, 32'hFFFF_FFFF, 0, 0);
        timer_val_i = 64'h0000_0008_0000_0055;
        op(1, 0, 2'd1, 0, 32'h0000_0008, 0, 0);
        op(0, 1, 2'd1, 32'h7, 0, 1, 64'h0000_0007_0000_0055);
        tick();

        // Simultaneous read and write of CMP_HI
        op(1, 1, 2'd3, 32'h1, 32'hFFFF_FFFF, 0, 0);
        op(1, 0, 2'd3, 0, 32'h0000_0001, 0, 0);

        // Compare interrupt
        timer_val_i = 64'hFE;
        op(0, 1, 2'd3, 32'h0, 0, 0, 0);
        op(0, 1, 2'd2, 32'h100, 0, 0, 0);
        for (int v = 'hFE; v <= 'h102; v++) begin
            timer_val_i = 64'(v);
            tick();
            chk("irq_ramp", {63'h0, irq_o}, {63'h0, (v >= 'h100)});
        end
        op(0, 1, 2'd2, 32'h50, 0, 0, 0);
        chk("irq_forced0", {63'h0, irq_o}, 64'h0);
        tick();
        chk("irq_resume", {63'h0, irq_o}, 64'h1);
        op(0, 1, 2'd2, 32'h200, 0, 0, 0);
        chk("irq_cmp_raise", {63'h0, irq_o}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("irq_stays0", {63'h0, irq_o}, 64'h0);
        end

        // Drain scoreboards
        for (int i = 0; i < 10 && (rdq.size() != 0 || ldq.size() != 0); i++) tick();
        chk("rdq_drained", 64'(rdq.size()), 64'h0);
        chk("ldq_drained", 64'(ldq.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
